// File: rtl/pixel_stream_receiver.sv
// -----------------------------------------------------------------------------
// pixel_stream_receiver
//
// Accepts multi-pixel beats from a sensor bus, buffers them in a small beat
// FIFO and serialises them into a one-pixel-per-transfer valid/ready stream.
// Each output pixel is tagged with its raster position and with start-of-frame,
// end-of-line and end-of-frame markers. Beats arriving while the FIFO is full
// are dropped. The number of beats received between sensor end-of-frame
// markers is checked against the expected frame size.
//
// Ports
//   output_clk      in   sole clock, rising edge
//   reset           in   synchronous, active-low
//   in_valid        in   in_data carries a beat this cycle
//   in_data         in   BUS_WIDTH pixels, lane 0 (lowest bits) = lowest column
//   frame_finished  in   sensor end-of-frame marker; falling edge closes a frame
//   out_valid       out  out_pixel and tags are valid
//   out_ready       in   downstream accepts; transfer = out_valid && out_ready
//   out_pixel       out  pixel value
//   out_col/out_row out  raster position of out_pixel
//   out_sof         out  first pixel of frame
//   out_eol         out  last pixel of row
//   out_eof         out  last pixel of frame
//   overflow        out  sticky: a beat was dropped on a full FIFO
//   frame_error     out  sticky: a frame closed with the wrong beat count
//   frame_count     out  completed output frames, modulo 2^16
// -----------------------------------------------------------------------------
module pixel_stream_receiver #(
    parameter int PIXEL_BITS   = 8,
    parameter int BUS_WIDTH    = 4,
    parameter int ARRAY_WIDTH  = 8,  // multiple of BUS_WIDTH
    parameter int ARRAY_HEIGHT = 8,
    parameter int FIFO_DEPTH   = 4   // power of two, at least 2
) (
    input  logic                            output_clk,
    input  logic                            reset,
    input  logic                            in_valid,
    input  logic [BUS_WIDTH*PIXEL_BITS-1:0] in_data,
    input  logic                            frame_finished,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [PIXEL_BITS-1:0]           out_pixel,
    output logic [$clog2(ARRAY_WIDTH)-1:0]  out_col,
    output logic [$clog2(ARRAY_HEIGHT)-1:0] out_row,
    output logic                            out_sof,
    output logic                            out_eol,
    output logic                            out_eof,
    output logic                            overflow,
    output logic                            frame_error,
    output logic [15:0]                     frame_count
);

    localparam int BEAT_W          = BUS_WIDTH * PIXEL_BITS;
    localparam int PTR_W           = $clog2(FIFO_DEPTH);
    localparam int CNT_W           = PTR_W + 1;
    localparam int LANE_W          = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;
    localparam int COL_W           = $clog2(ARRAY_WIDTH);
    localparam int ROW_W           = $clog2(ARRAY_HEIGHT);
    localparam int BEATS_PER_FRAME = ARRAY_WIDTH * ARRAY_HEIGHT / BUS_WIDTH;
    // One spare bit so the saturating counter can never alias the frame size.
    localparam int BEAT_CNT_W      = $clog2(BEATS_PER_FRAME + 1) + 1;
    localparam int CLOSE_W         = BEAT_CNT_W + 1;

    localparam logic [LANE_W-1:0]  LAST_LANE   = LANE_W'(BUS_WIDTH - 1);
    localparam logic [COL_W-1:0]   LAST_COL    = COL_W'(ARRAY_WIDTH - 1);
    localparam logic [ROW_W-1:0]   LAST_ROW    = ROW_W'(ARRAY_HEIGHT - 1);
    localparam logic [CNT_W-1:0]   FULL_CNT    = CNT_W'(FIFO_DEPTH);
    localparam logic [CLOSE_W-1:0] FRAME_BEATS = CLOSE_W'(BEATS_PER_FRAME);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,  // FIFO empty, nothing to present
        STREAM = 1'b1   // FIFO holds at least one beat, head pixel presented
    } state_t;

    state_t state_q, state_d;

    logic [BEAT_W-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      fifo_count_q, fifo_count_d;
    logic [LANE_W-1:0]     lane_idx_q;
    logic [COL_W-1:0]      col_q;
    logic [ROW_W-1:0]      row_q;
    logic [BEAT_CNT_W-1:0] beat_count_q;
    logic                  frame_finished_q;
    logic                  resync_pending_q;

    logic                  full, xfer, last_lane, pop, wr_en, drop;
    logic                  frame_fall, frame_err_event, resync_req, at_boundary;
    logic [CLOSE_W-1:0]    closing_count;
    logic [BEAT_W-1:0]     head_beat;
    logic                  col_last, row_last;

    // -------------------------------------------------------------------------
    // FIFO handshake
    // -------------------------------------------------------------------------
    assign full      = (fifo_count_q == FULL_CNT);
    assign xfer      = out_valid && out_ready;
    assign last_lane = (lane_idx_q == LAST_LANE);
    assign pop       = xfer && last_lane;
    // A pop frees the slot in the same cycle, so a full FIFO can still accept.
    assign wr_en     = in_valid && (!full || pop);
    assign drop      = in_valid && full && !pop;

    assign fifo_count_d = fifo_count_q + CNT_W'(wr_en) - CNT_W'(pop);

    // -------------------------------------------------------------------------
    // Frame-size check: a beat accepted on the closing edge still belongs to
    // the frame being closed.
    // -------------------------------------------------------------------------
    assign frame_fall      = frame_finished_q && !frame_finished;
    assign closing_count   = {1'b0, beat_count_q} + CLOSE_W'(wr_en);
    assign frame_err_event = frame_fall && (closing_count != FRAME_BEATS);

    // Position counters are only rewritten between beats so that a stalled
    // pixel never changes its tags. With no pixel presented the lane index is
    // necessarily 0, which is also a beat boundary.
    assign resync_req  = resync_pending_q || frame_err_event;
    assign at_boundary = pop || !out_valid;

    // -------------------------------------------------------------------------
    // State machine: the registered state mirrors FIFO occupancy, so a beat
    // written into an empty FIFO is presented on the following cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge output_clk) begin
        // NOTE: every register is updated with <= so all flops sample the
        // pre-edge values of each other, independent of statement order.
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: defaulting state_d before the case keeps every path assigned,
        // so no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:    if (fifo_count_d != '0) state_d = STREAM;
            STREAM:  if (fifo_count_d == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign out_valid = (state_q == STREAM);

    // -------------------------------------------------------------------------
    // Beat storage
    // -------------------------------------------------------------------------
    always_ff @(posedge output_clk) begin
        // NOTE: the storage array is deliberately left out of reset; the
        // pointers and occupancy count define which entries are meaningful.
        if (wr_en) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    assign head_beat = mem[rd_ptr_q];

    // -------------------------------------------------------------------------
    // Control and status registers
    // -------------------------------------------------------------------------
    always_ff @(posedge output_clk) begin
        if (!reset) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            fifo_count_q     <= '0;
            lane_idx_q       <= '0;
            col_q            <= '0;
            row_q            <= '0;
            beat_count_q     <= '0;
            frame_finished_q <= 1'b0;
            resync_pending_q <= 1'b0;
            overflow         <= 1'b0;
            frame_error      <= 1'b0;
            frame_count      <= '0;
        end else begin
            fifo_count_q     <= fifo_count_d;
            frame_finished_q <= frame_finished;

            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (drop)  overflow <= 1'b1;

            if (xfer) begin
                lane_idx_q <= last_lane ? '0 : lane_idx_q + LANE_W'(1);
            end

            // Saturate rather than wrap so a runaway frame cannot pass the check.
            if (frame_fall) begin
                beat_count_q <= '0;
            end else if (wr_en && !(&beat_count_q)) begin
                beat_count_q <= beat_count_q + BEAT_CNT_W'(1);
            end

            if (frame_err_event) frame_error <= 1'b1;

            if (resync_req && at_boundary) begin
                col_q            <= '0;
                row_q            <= '0;
                resync_pending_q <= 1'b0;
            end else begin
                if (frame_err_event) resync_pending_q <= 1'b1;
                if (xfer) begin
                    if (col_last) begin
                        col_q <= '0;
                        row_q <= row_last ? '0 : row_q + ROW_W'(1);
                    end else begin
                        col_q <= col_q + COL_W'(1);
                    end
                end
            end

            if (xfer && out_eof) frame_count <= frame_count + 16'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Output pixel and tags, forced to zero while nothing is presented
    // -------------------------------------------------------------------------
    assign col_last  = (col_q == LAST_COL);
    assign row_last  = (row_q == LAST_ROW);

    assign out_pixel = out_valid ? head_beat[lane_idx_q*PIXEL_BITS +: PIXEL_BITS] : '0;
    assign out_col   = out_valid ? col_q : '0;
    assign out_row   = out_valid ? row_q : '0;
    assign out_sof   = out_valid && (col_q == '0) && (row_q == '0);
    assign out_eol   = out_valid && col_last;
    assign out_eof   = out_eol && row_last;

endmodule

// File: tb/tb_pixel_stream_receiver.sv
// -----------------------------------------------------------------------------
// tb_pixel_stream_receiver
//
// Directed bench for pixel_stream_receiver. A scoreboard queue holds every
// pixel the bench expects to see leave the DUT, together with its raster
// position; a negedge monitor compares each transfer against it.
// -----------------------------------------------------------------------------
module tb_pixel_stream_receiver;

    localparam int PIXEL_BITS   = 8;
    localparam int BUS_WIDTH    = 4;
    localparam int ARRAY_WIDTH  = 8;
    localparam int ARRAY_HEIGHT = 8;
    localparam int FIFO_DEPTH   = 4;
    localparam int FRAME_PIX    = ARRAY_WIDTH * ARRAY_HEIGHT;

    logic        output_clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        frame_finished = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [7:0]  out_pixel;
    logic [2:0]  out_col;
    logic [2:0]  out_row;
    logic        out_sof, out_eol, out_eof;
    logic        overflow, frame_error;
    logic [15:0] frame_count;

    pixel_stream_receiver #(
        .PIXEL_BITS  (PIXEL_BITS),
        .BUS_WIDTH   (BUS_WIDTH),
        .ARRAY_WIDTH (ARRAY_WIDTH),
        .ARRAY_HEIGHT(ARRAY_HEIGHT),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .output_clk    (output_clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .frame_finished(frame_finished),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pixel     (out_pixel),
        .out_col       (out_col),
        .out_row       (out_row),
        .out_sof       (out_sof),
        .out_eol       (out_eol),
        .out_eof       (out_eof),
        .overflow      (overflow),
        .frame_error   (frame_error),
        .frame_count   (frame_count)
    );

    always #5 output_clk = ~output_clk;

    typedef struct {
        logic [7:0] pix;
        logic [2:0] col;
        logic [2:0] row;
    } exp_t;

    exp_t exp_q[$];
    int   exp_pos  = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge output_clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] pix);
        exp_t e;
        e.pix = pix;
        e.col = 3'(exp_pos % ARRAY_WIDTH);
        e.row = 3'(exp_pos / ARRAY_WIDTH);
        exp_q.push_back(e);
        exp_pos = (exp_pos + 1) % FRAME_PIX;
    endtask

    function automatic logic [31:0] make_beat(input int first);
        logic [31:0] b;
        for (int i = 0; i < BUS_WIDTH; i++) b[i*8 +: 8] = 8'(first + i);
        return b;
    endfunction

    // Sends n beats whose pixels count up from base. Never lets more than
    // three beats be outstanding, so the FIFO cannot overflow.
    task automatic send_beats(input int n, input int base, input bit rnd);
        int sent = 0;
        int cyc  = 0;
        while (sent < n && cyc < 4000) begin
            out_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            if (exp_q.size() <= 8) begin
                in_valid = 1'b1;
                in_data  = make_beat(base + 4 * sent);
                for (int i = 0; i < BUS_WIDTH; i++) push_exp(8'(base + 4 * sent + i));
                sent++;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check("beats_sent", 32'(sent), 32'(n));
    endtask

    task automatic drain(input bit rnd);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 2000) begin
            out_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            tick();
            cyc++;
        end
        out_ready = 1'b1;
        check("drain_empty", 32'(exp_q.size()), 32'(0));
    endtask

    // Scoreboard monitor: a transfer happens at the next rising edge.
    always @(negedge output_clk) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_xfer", 32'(out_valid), 32'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pix", 32'(out_pixel), 32'(e.pix));
                check("col", 32'(out_col), 32'(e.col));
                check("row", 32'(out_row), 32'(e.row));
                check("sof", 32'(out_sof), 32'(e.col == 3'd0 && e.row == 3'd0));
                check("eol", 32'(out_eol), 32'(e.col == 3'd7));
                check("eof", 32'(out_eof), 32'(e.col == 3'd7 && e.row == 3'd7));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        repeat (3) tick();
        check("rst_valid", 32'(out_valid), 32'(0));
        check("rst_pixel", 32'(out_pixel), 32'(0));
        check("rst_col", 32'(out_col), 32'(0));
        check("rst_row", 32'(out_row), 32'(0));
        check("rst_tags", 32'({out_sof, out_eol, out_eof}), 32'(0));
        check("rst_overflow", 32'(overflow), 32'(0));
        check("rst_frame_error", 32'(frame_error), 32'(0));
        check("rst_frame_count", 32'(frame_count), 32'(0));
        reset = 1'b1;
        tick();
        check("valid_after_release", 32'(out_valid), 32'(0));

        // ---------------- full frame, pixels 0..63 ----------------
        frame_finished = 1'b1;
        exp_pos = 0;
        send_beats(16, 0, 1'b0);
        drain(1'b0);
        frame_finished = 1'b0;
        tick();
        tick();
        check("f1_frame_count", 32'(frame_count), 32'(1));
        check("f1_frame_error", 32'(frame_error), 32'(0));
        check("f1_overflow", 32'(overflow), 32'(0));

        // ---------------- short frame (15 beats) then resync ----------------
        frame_finished = 1'b1;
        send_beats(15, 64, 1'b0);
        drain(1'b0);
        frame_finished = 1'b0;
        tick();
        tick();
        check("short_frame_error", 32'(frame_error), 32'(1));
        check("short_frame_count", 32'(frame_count), 32'(1));
        exp_pos = 0;
        frame_finished = 1'b1;
        tick();
        send_beats(16, 128, 1'b0);
        drain(1'b0);
        frame_finished = 1'b0;
        tick();
        tick();
        check("resync_frame_count", 32'(frame_count), 32'(2));
        check("resync_error_sticky", 32'(frame_error), 32'(1));

        // ---------------- reset mid-frame after beat 7 ----------------
        frame_finished = 1'b1;
        tick();
        send_beats(6, 200, 1'b0);
        drain(1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = make_beat(50);
        tick();
        in_valid = 1'b0;
        tick();
        check("b7_valid", 32'(out_valid), 32'(1));
        check("b7_pixel", 32'(out_pixel), 32'(50));
        check("b7_col", 32'(out_col), 32'(0));
        check("b7_row", 32'(out_row), 32'(3));
        reset = 1'b0;
        frame_finished = 1'b0;
        tick();
        check("mid_rst_valid", 32'(out_valid), 32'(0));
        check("mid_rst_tags", 32'({out_col, out_row, out_sof, out_eol, out_eof}), 32'(0));
        check("mid_rst_frame_count", 32'(frame_count), 32'(0));
        check("mid_rst_frame_error", 32'(frame_error), 32'(0));
        check("mid_rst_overflow", 32'(overflow), 32'(0));
        reset = 1'b1;
        tick();
        check("mid_rst_valid_after", 32'(out_valid), 32'(0));
        exp_pos = 0;
        frame_finished = 1'b1;
        tick();
        send_beats(16, 10, 1'b0);
        drain(1'b0);
        frame_finished = 1'b0;
        tick();
        tick();
        check("post_rst_frame_count", 32'(frame_count), 32'(1));
        check("post_rst_frame_error", 32'(frame_error), 32'(0));

        // ---------------- full FIFO with simultaneous pop and write ----------------
        out_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            in_valid = 1'b1;
            in_data  = make_beat(100 + 4 * b);
            tick();
        end
        in_valid = 1'b0;
        check("full_valid", 32'(out_valid), 32'(1));
        check("full_pixel", 32'(out_pixel), 32'(100));
        check("full_overflow", 32'(overflow), 32'(0));
        for (int k = 0; k < 20; k++) push_exp(8'(100 + k));
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        in_valid = 1'b1;
        in_data  = make_beat(116);
        tick();
        in_valid = 1'b0;
        check("pop_write_overflow", 32'(overflow), 32'(0));
        drain(1'b0);
        check("pop_write_overflow_end", 32'(overflow), 32'(0));

        // ---------------- overflow with stalled output ----------------
        out_ready = 1'b0;
        for (int b = 0; b < 6; b++) begin
            in_valid = 1'b1;
            in_data  = make_beat(150 + 4 * b);
            tick();
            if (b == 3) check("ovf_after_4", 32'(overflow), 32'(0));
            if (b == 4) check("ovf_after_5", 32'(overflow), 32'(1));
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("stall_valid", 32'(out_valid), 32'(1));
            check("stall_pixel", 32'(out_pixel), 32'(150));
            check("stall_col", 32'(out_col), 32'(4));
            check("stall_row", 32'(out_row), 32'(2));
            check("stall_sof", 32'(out_sof), 32'(0));
            tick();
        end
        for (int k = 0; k < 16; k++) push_exp(8'(150 + k));
        drain(1'b0);
        check("ovf_sticky", 32'(overflow), 32'(1));

        // ---------------- three frames with random out_ready ----------------
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rst2_overflow", 32'(overflow), 32'(0));
        check("rst2_frame_count", 32'(frame_count), 32'(0));
        exp_pos = 0;
        for (int f = 0; f < 3; f++) begin
            frame_finished = 1'b1;
            tick();
            send_beats(16, 5 + 64 * f, 1'b1);
            drain(1'b1);
            frame_finished = 1'b0;
            tick();
            tick();
        end
        check("rand_frame_count", 32'(frame_count), 32'(3));
        check("rand_frame_error", 32'(frame_error), 32'(0));
        check("rand_overflow", 32'(overflow), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
